cpu_mem_bridge: RTL and testbench
=================================

# cpu_mem_bridge

CPU-side initiator between the 6502 core and the PSRAM memory controller, running in the clkPhi0 domain. It emulates the 6510 on-chip port at $0000/$0001 and decodes the C64 banking (BASIC, KERNAL, CHAR ROM, I/O, RAM) into a 6-bit bank number. Every other CPU access becomes a CE/busy/dataReady handshake with the controller, and the CPU is stalled via RDY until the access completes. It replaces the hand-driven memCtrl signals in the top level.

## Interface
- TIMEOUT_CYCLES, 255: clkPhi0 cycles allowed in ISSUE+WAIT before abort.
- clkPhi0  in  1  CPU clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- cpuAddr  in  16  CPU address bus (AB).
- cpuDataOut  in  8  CPU write data (DO).
- cpuWE  in  1  CPU write enable.
- cpuDataIn  out  8  read data to CPU (DI).
- rdy  out  1  CPU RDY; low stalls the core.
- memCE  out  1  request to memory controller.
- memWrite  out  1  1 = write, 0 = read.
- memBank  out  6  bank number.
- memAddr  out  16  address to controller.
- memDataToWrite  out  8  write data.
- memBusy  in  1  controller busy (clkRAM domain).
- memDataReady  in  1  controller read data valid (clkRAM domain).
- memDataRead  in  8  controller read data, stable while memDataReady=1.
- port01  out  8  current $0001 output value (for tape/debug).
- timeoutErr  out  1  sticky; set on any aborted access.

## Operation
- Port registers: ddr ($0000) resets to 0x2F, port ($0001) to 0x37. Effective bits p[2:0] = (port & ddr) | ~ddr; LORAM=p0, HIRAM=p1, CHAREN=p2. port01 = port.
- Bank decode (reads): $A000-$BFFF -> 1 (BASIC) if LORAM&HIRAM; $E000-$FFFF -> 2 (KERNAL) if HIRAM; $D000-$DFFF -> 4 (I/O) if (LORAM|HIRAM)&CHAREN, 3 (CHAR) if (LORAM|HIRAM)&!CHAREN; otherwise 0 (RAM).
- Bank decode (writes): 4 when the read decode yields 4, otherwise 0 (writes under ROM go to RAM).
- Local access ($0000/$0001): no controller traffic. Read returns ddr/port (port reads return p on bits 2:0, port bits 7:3). Write updates the register at the edge; new banking applies from the next access.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: local access -> stay, rdy=1. External access -> latch addr/bank/write/data into mem* outputs, memCE<=1, clear timer, go ISSUE.
- ISSUE: hold memCE=1 and all mem* stable. When sync(memBusy)=1: memCE<=0, go WAIT.
- WAIT: read completes on sync(memDataReady)=1 (latch memDataRead into cpuDataIn). Write completes on sync(memBusy)=0. On completion go DONE.
- DONE: rdy=1 for exactly one cycle, then IDLE.
- Timeout: the timer increments each ISSUE/WAIT cycle. When it reaches TIMEOUT_CYCLES: memCE<=0, cpuDataIn<=0xFF (reads), timeoutErr<=1, go DONE.
- rdy is combinational: 1 in DONE, or in IDLE with a local address; 0 otherwise.

## Timing
- memBusy and memDataReady pass through 2-flop synchronisers; all decisions use the synchronised versions.
- Reset values: state IDLE, memCE 0, memWrite 0, memBank 0, memAddr 0, memDataToWrite 0, cpuDataIn 0x00, timeoutErr 0, ddr 0x2F, port 0x37, timer 0, synchronisers 0.
- Best-case external latency: edge 0 (IDLE) -> CE high; busy seen after 2 sync cycles; completion seen 2 cycles after the controller event; DONE 1 cycle. Minimum rdy low for a read is 4 cycles.
- memAddr, memBank, memWrite and memDataToWrite are constant from the IDLE exit until the next IDLE exit.
- If sync(memDataReady)=1 is seen in ISSUE (fast controller, busy missed), treat it as busy+completion: go DONE directly with the data latched.
- Reset mid-access: abort immediately and drop memCE. The controller must tolerate CE loss; no retry.
- Timer width is ceil(log2(TIMEOUT_CYCLES+1)) and it saturates; no wrap.

## Test plan
- Reset: after release, rdy=1 for cpuAddr=$0001; read returns 0x37; memCE stays 0 for 10 cycles.
- Read $E000 with stub returning 0x4C: memBank=2, memWrite=0, memCE held until busy; rdy pulses one cycle; cpuDataIn=0x4C.
- Write 0x35 to $0001, then read $E000: memBank=0. Read $D020: memBank=4.
- Write 0x0E to $D020: memWrite=1, memBank=4, memDataToWrite=0x0E; rdy high one cycle after busy falls. Write to $A000: memBank=0.
- Stub never asserts busy: rdy low for TIMEOUT_CYCLES cycles, then cpuDataIn=0xFF, timeoutErr=1 (stays set); the next access proceeds normally.
- Assert reset during WAIT: memCE=0 and all outputs at reset values immediately; port01=0x37.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// CPU-side bridge between the 6502 core and the PSRAM controller: emulates the
// 6510 port at $0000/$0001, decodes C64 banking and stalls the core via RDY.
module cpu_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clkPhi0,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuWE,
  output logic [7:0]  cpuDataIn,
  output logic        rdy,
  output logic        memCE,
  output logic        memWrite,
  output logic [5:0]  memBank,
  output logic [15:0] memAddr,
  output logic [7:0]  memDataToWrite,
  input  logic        memBusy,
  input  logic        memDataReady,
  input  logic [7:0]  memDataRead,
  output logic [7:0]  port01,
  output logic        timeoutErr
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX_M1 = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ce_q, ce_d;
  logic          we_q, we_d;
  logic [5:0]    bank_q, bank_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          terr_q, terr_d;
  logic [7:0]    ddr_q, ddr_d;
  logic [7:0]    port_q, port_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    busy_sync_q;
  logic [1:0]    ready_sync_q;

  logic          busy_s, ready_s;
  logic          is_local;
  logic [2:0]    p_eff;
  logic          loram, hiram, charen;
  logic [5:0]    rd_bank, wr_bank;
  logic [7:0]    local_rd;
  logic          timed_out;

  assign busy_s   = busy_sync_q[1];
  assign ready_s  = ready_sync_q[1];
  assign is_local = (cpuAddr[15:1] == 15'd0);

  // Bits configured as inputs read back as 1 (pull-ups on the real 6510 port).
  assign p_eff  = (port_q[2:0] & ddr_q[2:0]) | ~ddr_q[2:0];
  assign loram  = p_eff[0];
  assign hiram  = p_eff[1];
  assign charen = p_eff[2];

  always_comb begin
    rd_bank = '0;
    case (cpuAddr[15:12])
      4'hA, 4'hB: if (loram && hiram) rd_bank = 6'd1;
      4'hD:       if (loram || hiram) rd_bank = charen ? 6'd4 : 6'd3;
      4'hE, 4'hF: if (hiram) rd_bank = 6'd2;
      default:    rd_bank = '0;
    endcase
  end

  // Writes under ROM land in RAM; only I/O keeps its own bank.
  assign wr_bank  = (rd_bank == 6'd4) ? 6'd4 : '0;
  assign local_rd = cpuAddr[0] ? {port_q[7:3], p_eff} : ddr_q;
  assign timed_out = (timer_q >= TMAX_M1);

  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    we_d    = we_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;
    ddr_d   = ddr_q;
    port_d  = port_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (is_local) begin
          if (cpuWE) begin
            if (cpuAddr[0]) port_d = cpuDataOut;
            else            ddr_d  = cpuDataOut;
          end
        end else begin
          addr_d  = cpuAddr;
          bank_d  = cpuWE ? wr_bank : rd_bank;
          we_d    = cpuWE;
          wdata_d = cpuDataOut;
          ce_d    = 1'b1;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        if (!we_q && ready_s) begin
          // Controller finished before busy was seen through the synchroniser.
          rdata_d = memDataRead;
          ce_d    = 1'b0;
          state_d = S_DONE;
        end else if (busy_s) begin
          ce_d    = 1'b0;
          state_d = S_WAIT;
        end else if (timed_out) begin
          ce_d    = 1'b0;
          if (!we_q) rdata_d = 8'hFF;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        if (we_q ? !busy_s : ready_s) begin
          if (!we_q) rdata_d = memDataRead;
          state_d = S_DONE;
        end else if (timed_out) begin
          ce_d    = 1'b0;
          if (!we_q) rdata_d = 8'hFF;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkPhi0 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      bank_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      terr_q       <= 1'b0;
      ddr_q        <= 8'h2F;
      port_q       <= 8'h37;
      timer_q      <= '0;
      busy_sync_q  <= '0;
      ready_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      bank_q       <= bank_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      terr_q       <= terr_d;
      ddr_q        <= ddr_d;
      port_q       <= port_d;
      timer_q      <= timer_d;
      busy_sync_q  <= {busy_sync_q[0], memBusy};
      ready_sync_q <= {ready_sync_q[0], memDataReady};
    end
  end

  assign rdy            = (state_q == S_DONE) || ((state_q == S_IDLE) && is_local);
  assign cpuDataIn      = ((state_q == S_IDLE) && is_local) ? local_rd : rdata_q;
  assign memCE          = ce_q;
  assign memWrite       = we_q;
  assign memBank        = bank_q;
  assign memAddr        = addr_q;
  assign memDataToWrite = wdata_q;
  assign port01         = port_q;
  assign timeoutErr     = terr_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge with a behavioural controller stub that
// answers CE with a busy pulse followed (for reads) by a data-ready window.
module tb_cpu_mem_bridge;
  localparam int unsigned TO = 255;

  logic        clkPhi0;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataOut;
  logic        cpuWE;
  logic [7:0]  cpuDataIn;
  logic        rdy;
  logic        memCE;
  logic        memWrite;
  logic [5:0]  memBank;
  logic [15:0] memAddr;
  logic [7:0]  memDataToWrite;
  logic        memBusy;
  logic        memDataReady;
  logic [7:0]  memDataRead;
  logic [7:0]  port01;
  logic        timeoutErr;

  int checks = 0;
  int failures = 0;

  logic        stub_respond = 1'b1;
  logic [7:0]  stub_data = 8'h00;

  int          lowc;
  logic        cap_ce1, cap_ce4, cap_ce6, cap_wr, cap_rdy_after;
  logic [5:0]  cap_bank;
  logic [7:0]  cap_wd, cap_data;
  logic [15:0] cap_addr;
  logic        ce_seen;

  cpu_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clkPhi0(clkPhi0), .reset(reset),
    .cpuAddr(cpuAddr), .cpuDataOut(cpuDataOut), .cpuWE(cpuWE),
    .cpuDataIn(cpuDataIn), .rdy(rdy),
    .memCE(memCE), .memWrite(memWrite), .memBank(memBank), .memAddr(memAddr),
    .memDataToWrite(memDataToWrite), .memBusy(memBusy),
    .memDataReady(memDataReady), .memDataRead(memDataRead),
    .port01(port01), .timeoutErr(timeoutErr)
  );

  initial clkPhi0 = 1'b0;
  always #5 clkPhi0 = ~clkPhi0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Controller stub: busy one cycle after CE, held 3 cycles, then data-ready for 4.
  initial begin
    logic was_wr;
    memBusy = 1'b0; memDataReady = 1'b0; memDataRead = 8'h00;
    forever begin
      @(negedge clkPhi0);
      if (memCE === 1'b1 && stub_respond) begin
        was_wr = memWrite;
        @(negedge clkPhi0); memBusy = 1'b1;
        repeat (3) @(negedge clkPhi0);
        memBusy = 1'b0;
        if (!was_wr) begin
          memDataRead = stub_data; memDataReady = 1'b1;
          repeat (4) @(negedge clkPhi0);
          memDataReady = 1'b0; memDataRead = 8'h00;
        end
      end
    end
  end

  // lowc counts falling edges from presenting the address until rdy is seen high.
  task automatic access(input logic [15:0] a, input logic we, input logic [7:0] d);
    @(negedge clkPhi0);
    cpuAddr = a; cpuWE = we; cpuDataOut = d;
    #1;
    lowc = 0; cap_ce4 = 1'bx; cap_ce6 = 1'bx;
    while (rdy !== 1'b1 && lowc < 400) begin
      @(negedge clkPhi0);
      lowc++;
      if (lowc == 1) begin
        cap_ce1 = memCE; cap_bank = memBank; cap_wr = memWrite;
        cap_wd = memDataToWrite; cap_addr = memAddr;
      end
      if (lowc == 4) cap_ce4 = memCE;
      if (lowc == 6) cap_ce6 = memCE;
    end
    cap_data = cpuDataIn;
    @(negedge clkPhi0);
    cap_rdy_after = rdy;
    cpuAddr = 16'h0001; cpuWE = 1'b0; cpuDataOut = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; cpuAddr = 16'h0001; cpuWE = 1'b0; cpuDataOut = 8'h00;
    repeat (3) @(negedge clkPhi0);
    reset = 1'b1;
    #1;
    chk("rst_rdy",     32'(rdy),        32'd1);
    chk("rst_port_rd", 32'(cpuDataIn),  32'h37);
    chk("rst_port01",  32'(port01),     32'h37);
    chk("rst_terr",    32'(timeoutErr), 32'd0);
    ce_seen = 1'b0;
    repeat (10) begin
      @(negedge clkPhi0);
      if (memCE !== 1'b0) ce_seen = 1'b1;
    end
    chk("rst_ce_quiet", 32'(ce_seen), 32'd0);
    cpuAddr = 16'h0000; #1;
    chk("rst_ddr_rd", 32'(cpuDataIn), 32'h2F);
    cpuAddr = 16'h0001;

    // KERNAL read with default banking
    stub_data = 8'h4C;
    access(16'hE000, 1'b0, 8'h00);
    chk("k_ce",      32'(cap_ce1),       32'd1);
    chk("k_bank",    32'(cap_bank),      32'd2);
    chk("k_wr",      32'(cap_wr),        32'd0);
    chk("k_addr",    32'(cap_addr),      32'hE000);
    chk("k_ce_hold", 32'(cap_ce4),       32'd1);
    chk("k_ce_drop", 32'(cap_ce6),       32'd0);
    chk("k_lat",     32'(lowc),          32'd8);
    chk("k_data",    32'(cap_data),      32'h4C);
    chk("k_pulse",   32'(cap_rdy_after), 32'd0);

    // Local write to $0001: banks out BASIC/KERNAL, keeps I/O
    @(negedge clkPhi0);
    cpuAddr = 16'h0001; cpuWE = 1'b1; cpuDataOut = 8'h35;
    #1;
    chk("lw_rdy", 32'(rdy), 32'd1);
    @(negedge clkPhi0);
    cpuWE = 1'b0;
    #1;
    chk("lw_port01", 32'(port01),    32'h35);
    chk("lw_rd",     32'(cpuDataIn), 32'h35);

    stub_data = 8'h11;
    access(16'hE000, 1'b0, 8'h00);
    chk("ram_bank", 32'(cap_bank), 32'd0);
    chk("ram_data", 32'(cap_data), 32'h11);

    stub_data = 8'h06;
    access(16'hD020, 1'b0, 8'h00);
    chk("io_bank", 32'(cap_bank), 32'd4);
    chk("io_data", 32'(cap_data), 32'h06);

    access(16'hD020, 1'b1, 8'h0E);
    chk("iow_wr",   32'(cap_wr),   32'd1);
    chk("iow_bank", 32'(cap_bank), 32'd4);
    chk("iow_wd",   32'(cap_wd),   32'h0E);
    chk("iow_lat",  32'(lowc),     32'd8);

    access(16'hA000, 1'b1, 8'h55);
    chk("aw_bank", 32'(cap_bank), 32'd0);
    chk("aw_wr",   32'(cap_wr),   32'd1);
    chk("aw_terr", 32'(timeoutErr), 32'd0);

    // Unresponsive controller: includes the IDLE cycle the address is first presented
    stub_respond = 1'b0;
    access(16'hE000, 1'b0, 8'h00);
    stub_respond = 1'b1;
    chk("to_lat",  32'(lowc),       32'(TO + 1));
    chk("to_ce",   32'(cap_ce6),    32'd1);
    chk("to_data", 32'(cap_data),   32'hFF);
    chk("to_terr", 32'(timeoutErr), 32'd1);

    stub_data = 8'h99;
    access(16'hD000, 1'b0, 8'h00);
    chk("post_bank", 32'(cap_bank),   32'd4);
    chk("post_data", 32'(cap_data),   32'h99);
    chk("post_lat",  32'(lowc),       32'd8);
    chk("post_terr", 32'(timeoutErr), 32'd1);

    // Reset asserted while the read sits in WAIT
    stub_data = 8'h77;
    @(negedge clkPhi0);
    cpuAddr = 16'hE000; cpuWE = 1'b0; cpuDataOut = 8'hA5;
    repeat (6) @(negedge clkPhi0);
    chk("mid_addr", 32'(memAddr), 32'hE000);
    reset = 1'b0;
    #1;
    chk("mr_ce",    32'(memCE),          32'd0);
    chk("mr_wr",    32'(memWrite),       32'd0);
    chk("mr_bank",  32'(memBank),        32'd0);
    chk("mr_addr",  32'(memAddr),        32'd0);
    chk("mr_wd",    32'(memDataToWrite), 32'd0);
    chk("mr_din",   32'(cpuDataIn),      32'd0);
    chk("mr_terr",  32'(timeoutErr),     32'd0);
    chk("mr_port",  32'(port01),         32'h37);
    chk("mr_rdy",   32'(rdy),            32'd0);
    @(negedge clkPhi0);
    cpuAddr = 16'h0001; cpuDataOut = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clkPhi0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
